// File: rtl/sum_accumulator.sv
// Frame accumulator: sums COUNT adder results and presents each total over a valid/ready handshake.
// Define SUM_ACCUMULATOR_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module sum_accumulator #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 6,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               outValid_q, outValid_d;
  logic [ACC_W-1:0]   outSum_q, outSum_d;
  logic               outOvf_q, outOvf_d;

  logic               accept;
  logic               inIdle;
  logic [ACC_W-1:0]   accBase;
  logic [7:0]         cntBase;
  logic [ACC_W:0]     sumWide;
  logic               carry;
  logic               ovfNext;
  logic [ACC_W-1:0]   accNext;
  logic               lastSample;

  assign in_ready  = (state_q != HOLD) && !clear && rst_n;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == ACCUM) || (state_q == HOLD);
  assign out_valid = outValid_q;
  assign out_sum   = outSum_q;
  assign out_ovf   = outOvf_q;

  // A sample taken in IDLE starts a fresh frame, so the datapath sees a zero partial sum there.
  assign inIdle  = (state_q == IDLE);
  assign accBase = inIdle ? '0 : acc_q;
  assign cntBase = inIdle ? 8'd0 : cnt_q;
  assign sumWide = {1'b0, accBase} + (ACC_W+1)'(in_data);
  assign carry   = sumWide[ACC_W];
  assign ovfNext = (inIdle ? 1'b0 : ovf_q) | carry;

`ifdef SUM_ACCUMULATOR_SATURATE_EN
  assign accNext = ovfNext ? '1 : sumWide[ACC_W-1:0];
`else
  assign accNext = sumWide[ACC_W-1:0];
`endif

  assign lastSample = (inIdle && (COUNT == 1)) ||
                      ((state_q == ACCUM) && (cnt_q == LAST_CNT));

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    outValid_d = outValid_q;
    outSum_d   = outSum_q;
    outOvf_d   = outOvf_q;

    if (clear) begin
      state_d    = IDLE;
      acc_d      = '0;
      cnt_d      = 8'd0;
      ovf_d      = 1'b0;
      outValid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_d = accNext;
            cnt_d = cntBase + 8'd1;
            ovf_d = ovfNext;
            if (lastSample) begin
              state_d    = HOLD;
              outSum_d   = accNext;
              outOvf_d   = ovfNext;
              outValid_d = 1'b1;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d    = IDLE;
            outValid_d = 1'b0;
            acc_d      = '0;
            cnt_d      = 8'd0;
            ovf_d      = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= 8'd0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
      outSum_q   <= '0;
      outOvf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      outValid_q <= outValid_d;
      outSum_q   <= outSum_d;
      outOvf_q   <= outOvf_d;
    end
  end

endmodule
